// File: rtl/mem_access_pkg.sv
// Shared size encodings, FSM state type and helpers for the MEM-stage access unit.
package mem_access_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam int DEFAULT_TIMEOUT = 255;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   // Encoding 2'b11 behaves as a word access.
   function automatic logic [1:0] norm_size(input logic [1:0] size);
      return (size == 2'b11) ? SZ_WORD : size;
   endfunction

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
      case (size)
         SZ_BYTE: return 1'b0;
         SZ_HALF: return offset[0];
         default: return offset != 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/load_extend.sv
// Lane select and sign/zero extension of a little-endian bus word for loads.
module load_extend
   import mem_access_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   input  logic [1:0]  offset,
   input  logic [31:0] word,
   output logic [31:0] data
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane = word[{offset, 3'b000} +: 8];
      half_lane = offset[1] ? word[31:16] : word[15:0];
      case (size)
         SZ_BYTE: data = {{24{byte_lane[7] & ~is_unsigned}}, byte_lane};
         SZ_HALF: data = {{16{half_lane[15] & ~is_unsigned}}, half_lane};
         default: data = word;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store bus master with stall, misalign detection and ack timeout.
// Define MEM_SUBWORD_ACCESS_EN to enable byte/half accesses; otherwise every access is a word.
//
// state | meaning
// IDLE  | no access in flight; an aligned request starts one
// WAIT  | bus request held, waiting for ack or timeout
// DONE  | load data valid (or bus error), pipeline released
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_mem_read,
   input  logic        i_mem_write,
   input  logic [1:0]  i_size,
   input  logic        i_unsigned,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata,
   output logic        o_stall,
   output logic        o_misalign,
   output logic        o_bus_err,
   output logic        o_bus_req,
   output logic        o_bus_we,
   output logic [31:0] o_bus_addr,
   output logic [31:0] o_bus_wdata,
   output logic [3:0]  o_bus_be,
   input  logic        i_bus_ack,
   input  logic [31:0] i_bus_rdata
);

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state;
   logic [7:0]  wait_cnt;
   logic [1:0]  size_eff;
   logic        uns_eff;
   logic [1:0]  size_q;
   logic        uns_q;
   logic [1:0]  offset_q;
   logic        req;
   logic        start;
   logic [3:0]  be_next;
   logic [31:0] wdata_next;
   logic [31:0] load_data;

`ifdef MEM_SUBWORD_ACCESS_EN
   assign size_eff = norm_size(i_size);
   assign uns_eff  = i_unsigned;
`else
   logic unused_size_cfg;
   assign unused_size_cfg = ^{i_size, i_unsigned};
   assign size_eff = SZ_WORD;
   assign uns_eff  = 1'b0;
`endif

   assign req        = i_mem_read | i_mem_write;
   assign o_misalign = req & is_misaligned(size_eff, i_addr[1:0]);
   assign start      = (state == IDLE) & req & ~o_misalign;
   assign o_stall    = start | (state == WAIT);

   // Store data is replicated so every enabled lane carries the right bytes.
   always_comb begin
      case (size_eff)
         SZ_BYTE: begin
            be_next    = 4'b0001 << i_addr[1:0];
            wdata_next = {4{i_wdata[7:0]}};
         end
         SZ_HALF: begin
            be_next    = i_addr[1] ? 4'b1100 : 4'b0011;
            wdata_next = {2{i_wdata[15:0]}};
         end
         default: begin
            be_next    = 4'b1111;
            wdata_next = i_wdata;
         end
      endcase
   end

   load_extend u_load_extend (
      .size        (size_q),
      .is_unsigned (uns_q),
      .offset      (offset_q),
      .word        (i_bus_rdata),
      .data        (load_data)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         wait_cnt    <= 8'd0;
         o_rdata     <= 32'd0;
         o_bus_req   <= 1'b0;
         o_bus_we    <= 1'b0;
         o_bus_addr  <= 32'd0;
         o_bus_wdata <= 32'd0;
         o_bus_be    <= 4'd0;
         o_bus_err   <= 1'b0;
         size_q      <= SZ_WORD;
         uns_q       <= 1'b0;
         offset_q    <= 2'd0;
      end else begin
         o_bus_err <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state       <= WAIT;
                  wait_cnt    <= 8'd0;
                  o_bus_req   <= 1'b1;
                  o_bus_we    <= i_mem_write;
                  o_bus_addr  <= {i_addr[31:2], 2'b00};
                  o_bus_wdata <= wdata_next;
                  o_bus_be    <= be_next;
                  size_q      <= size_eff;
                  uns_q       <= uns_eff;
                  offset_q    <= i_addr[1:0];
               end
            end
            WAIT: begin
               // An ack in the final wait cycle still wins over the timeout.
               if (i_bus_ack) begin
                  o_rdata   <= load_data;
                  o_bus_req <= 1'b0;
                  state     <= DONE;
               end else if (wait_cnt == TMO_LAST) begin
                  o_rdata   <= 32'd0;
                  o_bus_err <= 1'b1;
                  o_bus_req <= 1'b0;
                  state     <= DONE;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomized checks of mem_access_unit against a behavioural model.
// The model follows MEM_SUBWORD_ACCESS_EN the same way as the design build.
module tb_mem_access_unit;

   localparam int T = 4;

   logic        clk;
   logic        reset;
   logic        i_mem_read, i_mem_write, i_unsigned, i_bus_ack;
   logic [1:0]  i_size;
   logic [31:0] i_addr, i_wdata, i_bus_rdata;
   logic [31:0] o_rdata, o_bus_addr, o_bus_wdata;
   logic        o_stall, o_misalign, o_bus_err, o_bus_req, o_bus_we;
   logic [3:0]  o_bus_be;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] last_rdata, last_addr, last_wdata, exp_hold;
   logic [3:0]  last_be;
   logic        last_we, last_err, last_mis, hold_known;
   int          last_stalls;

   mem_access_unit #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .reset(reset),
      .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
      .i_size(i_size), .i_unsigned(i_unsigned),
      .i_addr(i_addr), .i_wdata(i_wdata),
      .o_rdata(o_rdata), .o_stall(o_stall), .o_misalign(o_misalign),
      .o_bus_err(o_bus_err), .o_bus_req(o_bus_req), .o_bus_we(o_bus_we),
      .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata), .o_bus_be(o_bus_be),
      .i_bus_ack(i_bus_ack), .i_bus_rdata(i_bus_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // 0 byte, 1 half, 2 word
   function automatic int eff_size(input logic [1:0] s);
`ifdef MEM_SUBWORD_ACCESS_EN
      return (s == 2'd3) ? 2 : int'(s);
`else
      return 2;
`endif
   endfunction

   function automatic bit model_mis(input int sz, input logic [31:0] a);
      if (sz == 1) return (a % 2) != 0;
      if (sz == 2) return (a % 4) != 0;
      return 1'b0;
   endfunction

   function automatic logic [31:0] model_load(input int sz, input bit u, input logic [31:0] a,
                                              input logic [31:0] d);
      logic [31:0] v;
      if (sz == 0) begin
         v = (d >> (8 * (a % 4))) % 256;
         if (!u && v >= 128) v = v + 32'hFFFF_FF00;
      end else if (sz == 1) begin
         v = (d >> (16 * ((a / 2) % 2))) % 65536;
         if (!u && v >= 32768) v = v + 32'hFFFF_0000;
      end else begin
         v = d;
      end
      return v;
   endfunction

   function automatic logic [31:0] model_be(input int sz, input logic [31:0] a);
      if (sz == 0) return 32'(1 << (a % 4));
      if (sz == 1) return 32'(3 << (2 * ((a / 2) % 2)));
      return 32'd15;
   endfunction

   function automatic logic [31:0] model_wdata(input int sz, input logic [31:0] w);
      if (sz == 0) return (w % 256) * 32'h0101_0101;
      if (sz == 1) return (w % 65536) * 32'h0001_0001;
      return w;
   endfunction

   // Starts in the IDLE cycle (just after a posedge) and ends in the following IDLE cycle.
   task automatic do_access(input bit r, input bit w, input logic [1:0] s, input bit u,
                            input logic [31:0] a, input logic [31:0] wd, input int ack_at,
                            input logic [31:0] rd_word);
      int sz;
      bit mis, acked;
      int stalls;
      sz  = eff_size(s);
      mis = model_mis(sz, a);
      i_mem_read = r; i_mem_write = w; i_size = s; i_unsigned = u;
      i_addr = a; i_wdata = wd; i_bus_ack = 1'b0;
      #1;
      last_mis = o_misalign;
      chk("misalign", {31'd0, o_misalign}, {31'd0, mis});
      chk("stall_idle", {31'd0, o_stall}, {31'd0, !mis});
      if (mis) begin
         @(posedge clk); #1;
         chk("no_req_misalign", {31'd0, o_bus_req}, 32'd0);
         chk("stall_misalign", {31'd0, o_stall}, 32'd0);
         i_mem_read = 1'b0; i_mem_write = 1'b0;
         last_stalls = 0;
         #1;
         return;
      end
      stalls = 1;
      acked  = 1'b0;
      for (int c = 1; c <= T; c++) begin
         @(posedge clk); #1;
         chk("bus_req_wait", {31'd0, o_bus_req}, 32'd1);
         chk("stall_wait", {31'd0, o_stall}, 32'd1);
         chk("bus_addr", o_bus_addr, a & 32'hFFFF_FFFC);
         chk("bus_be", {28'd0, o_bus_be}, model_be(sz, a));
         chk("bus_we", {31'd0, o_bus_we}, {31'd0, w});
         if (w) chk("bus_wdata", o_bus_wdata, model_wdata(sz, wd));
         if (o_stall) stalls++;
         last_addr = o_bus_addr; last_be = o_bus_be; last_we = o_bus_we; last_wdata = o_bus_wdata;
         i_bus_ack   = (c == ack_at);
         i_bus_rdata = (c == ack_at) ? rd_word : $urandom;
         if (c == ack_at) begin
            acked = 1'b1;
            break;
         end
      end
      @(posedge clk); #1;
      i_bus_ack   = 1'($urandom % 2);
      i_bus_rdata = $urandom;
      last_stalls = stalls;
      last_rdata  = o_rdata;
      last_err    = o_bus_err;
      chk("stall_done", {31'd0, o_stall}, 32'd0);
      chk("bus_req_done", {31'd0, o_bus_req}, 32'd0);
      chk("bus_err_done", {31'd0, o_bus_err}, {31'd0, !acked});
      chk("stall_cycles", 32'(stalls), 32'(1 + (acked ? ack_at : T)));
      if (!w) begin
         exp_hold   = acked ? model_load(sz, u, a, rd_word) : 32'd0;
         hold_known = 1'b1;
         chk("rdata_done", o_rdata, exp_hold);
      end else begin
         hold_known = 1'b0;
      end
      @(posedge clk); #1;
      i_mem_read = 1'b0; i_mem_write = 1'b0; i_bus_ack = 1'b0;
      #1;
      chk("bus_err_pulse", {31'd0, o_bus_err}, 32'd0);
      chk("stall_after", {31'd0, o_stall}, 32'd0);
      chk("bus_req_after", {31'd0, o_bus_req}, 32'd0);
      if (hold_known) chk("rdata_hold", o_rdata, exp_hold);
   endtask

   task automatic idle_noise();
      i_bus_ack = 1'b1;
      i_bus_rdata = $urandom;
      @(posedge clk); #1;
      i_bus_ack = 1'b0;
      chk("idle_no_req", {31'd0, o_bus_req}, 32'd0);
      chk("idle_no_stall", {31'd0, o_stall}, 32'd0);
      if (hold_known) chk("idle_rdata_hold", o_rdata, exp_hold);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      i_mem_read = 1'b0; i_mem_write = 1'b0; i_size = 2'd0; i_unsigned = 1'b0;
      i_addr = 32'd0; i_wdata = 32'd0; i_bus_ack = 1'b0; i_bus_rdata = 32'd0;
      hold_known = 1'b0; exp_hold = 32'd0;
      #12;
      chk("rst_rdata", o_rdata, 32'd0);
      chk("rst_bus_req", {31'd0, o_bus_req}, 32'd0);
      chk("rst_bus_we", {31'd0, o_bus_we}, 32'd0);
      chk("rst_bus_addr", o_bus_addr, 32'd0);
      chk("rst_bus_wdata", o_bus_wdata, 32'd0);
      chk("rst_bus_be", {28'd0, o_bus_be}, 32'd0);
      chk("rst_bus_err", {31'd0, o_bus_err}, 32'd0);
      chk("rst_stall", {31'd0, o_stall}, 32'd0);
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;

      // lw, ack in the third wait cycle
      do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 3, 32'hDEAD_BEEF);
      chk("lw_stall_4", 32'(last_stalls), 32'd4);
      chk("lw_rdata", last_rdata, 32'hDEAD_BEEF);

      // lb / lbu at 0x103
      do_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'd0, 1, 32'h80FF_FFFF);
`ifdef MEM_SUBWORD_ACCESS_EN
      chk("lb_signed", last_rdata, 32'hFFFF_FF80);
`else
      chk("lb_as_lw_misalign", {31'd0, last_mis}, 32'd1);
`endif
      do_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'd0, 2, 32'h80FF_FFFF);
`ifdef MEM_SUBWORD_ACCESS_EN
      chk("lbu_unsigned", last_rdata, 32'h0000_0080);
      do_access(1'b1, 1'b0, 2'b01, 1'b0, 32'h002, 32'd0, 1, 32'h8001_0000);
      chk("lh_upper_signed", last_rdata, 32'hFFFF_8001);
`endif

      // sh at 0x202
      do_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'h0000_ABCD, 2, 32'd0);
`ifdef MEM_SUBWORD_ACCESS_EN
      chk("sh_be", {28'd0, last_be}, 32'hC);
      chk("sh_addr", last_addr, 32'h200);
      chk("sh_wdata", last_wdata, 32'hABCD_ABCD);
      chk("sh_we", {31'd0, last_we}, 32'd1);
`else
      chk("sh_as_sw_misalign", {31'd0, last_mis}, 32'd1);
`endif

      // misaligned lw
      do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'd0, 1, 32'd0);
      chk("lw_misalign", {31'd0, last_mis}, 32'd1);

      // load something non-zero so the timeout's zero result is visible
      do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h104, 32'd0, 1, 32'h1234_5678);
      do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h108, 32'd0, 100, 32'd0);
      chk("timeout_err", {31'd0, last_err}, 32'd1);
      chk("timeout_rdata", last_rdata, 32'd0);
      chk("timeout_stalls", 32'(last_stalls), 32'(T + 1));

      // ack in the last allowed wait cycle
      do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10C, 32'd0, T, 32'hCAFE_F00D);
      chk("ack_at_limit_rdata", last_rdata, 32'hCAFE_F00D);
      chk("ack_at_limit_err", {31'd0, last_err}, 32'd0);

      // read and write together: write wins
      do_access(1'b1, 1'b1, 2'b10, 1'b0, 32'h40, 32'h5555_AAAA, 1, 32'd0);
      chk("rw_write_wins", {31'd0, last_we}, 32'd1);

      // reset in the middle of WAIT
      i_mem_read = 1'b1; i_size = 2'b10; i_addr = 32'h300;
      @(posedge clk); #1;
      chk("pre_rst_req", {31'd0, o_bus_req}, 32'd1);
      #1 reset = 1'b0;
      #1;
      chk("rst_wait_req", {31'd0, o_bus_req}, 32'd0);
      chk("rst_wait_addr", o_bus_addr, 32'd0);
      chk("rst_wait_be", {28'd0, o_bus_be}, 32'd0);
      chk("rst_wait_rdata", o_rdata, 32'd0);
      i_mem_read = 1'b0;
      @(negedge clk) reset = 1'b1;
      exp_hold = 32'd0; hold_known = 1'b1;
      @(posedge clk); #1;
      idle_noise();
      do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'd0, 2, 32'h0BAD_F00D);
      chk("post_rst_lw", last_rdata, 32'h0BAD_F00D);

      for (int k = 0; k < 40; k++) begin
         bit r, w;
         logic [31:0] a;
         r = 1'($urandom % 2);
         w = 1'($urandom % 2);
         if (!r && !w) r = 1'b1;
         a = $urandom;
         if ($urandom % 2 == 0) a = a & 32'hFFFF_FFFC;
         do_access(r, w, 2'($urandom % 4), 1'($urandom % 2), a, $urandom,
                   int'($urandom_range(1, 6)), $urandom);
         if ($urandom % 2 == 0) idle_noise();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the number of WAIT cycles without ack before a bus error is declared (range 1..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have ports i_mem_read and i_mem_write, input, 1 bit each: the MEM-stage load and store requests.
REQ-005 The block SHALL have port i_size, input, 2 bits: 00 byte, 01 half, 10 word; 11 is treated as word.
REQ-006 The block SHALL have port i_unsigned, input, 1 bit: zero-extend the load when 1, sign-extend when 0.
REQ-007 The block SHALL have ports i_addr and i_wdata, input, 32 bits each: byte address and store data.
REQ-008 The block SHALL have port o_rdata, output, 32 bits: extended load data fed to the MEM/WB register.
REQ-009 The block SHALL have port o_stall, output, 1 bit: freezes PC, IF/ID, ID/EX and EX/MEM while high.
REQ-010 The block SHALL have port o_misalign, output, 1 bit: combinational misaligned-access flag.
REQ-011 The block SHALL have port o_bus_err, output, 1 bit: one-cycle timeout pulse.
REQ-012 The block SHALL have ports o_bus_req and o_bus_we, output, 1 bit each; o_bus_addr, output, 32 bits (word-aligned); o_bus_wdata, output, 32 bits; o_bus_be, output, 4 bits.
REQ-013 The block SHALL have ports i_bus_ack, input, 1 bit, and i_bus_rdata, input, 32 bits.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT and DONE.
REQ-015 In IDLE with an aligned request, the block SHALL assert o_stall combinationally in the same cycle, register address, byte enables and lane-shifted write data, and enter WAIT.
REQ-016 In WAIT, o_bus_req SHALL be high and the registered bus outputs SHALL be held stable, and o_stall SHALL be high.
REQ-017 On i_bus_ack in WAIT, the block SHALL capture the extended i_bus_rdata into o_rdata and enter DONE; minimum load latency is 2 cycles (IDLE to DONE).
REQ-018 In DONE, o_stall SHALL be low, o_rdata SHALL be valid, and the next state SHALL be IDLE.
REQ-019 If both i_mem_read and i_mem_write are asserted, the write SHALL take priority and the read SHALL be ignored.
REQ-020 Misalignment SHALL be detected as half with addr[0]=1, or word with addr[1:0]!=0; in that case o_misalign=1, no bus request is issued, o_stall=0, and the state remains IDLE.
REQ-021 The WAIT counter SHALL reach TIMEOUT_CYCLES, at which point the block SHALL enter DONE with o_rdata=0 and pulse o_bus_err for one cycle; the counter SHALL clear on entering WAIT.
REQ-022 i_bus_ack SHALL be ignored in IDLE and DONE.
REQ-023 For a load, the byte lane SHALL be selected by addr[1:0] (little-endian), and the half lane by addr[1].
REQ-024 For a store, byte enables SHALL be: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1]*2; word 4'b1111; write data SHALL be replicated across lanes.

Reset
REQ-025 While reset=0, state SHALL be IDLE, the counter 0, and all registered outputs 0 (o_rdata, o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be, o_bus_err).
REQ-026 Assertion of reset mid-WAIT SHALL drop o_bus_req immediately and abandon the access.

Configuration
REQ-027 With MEM_SUBWORD_ACCESS_EN defined, byte and half accesses SHALL be supported as specified.
REQ-028 Without MEM_SUBWORD_ACCESS_EN, i_size and i_unsigned SHALL be ignored, all accesses SHALL be word accesses (o_bus_be=4'b1111), and o_misalign SHALL be set only when addr[1:0]!=0.

Structure
REQ-029 Package mem_access_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state enum and the default timeout constant.
REQ-030 Sub-module load_extend SHALL perform the combinational lane select and sign/zero extension.

Verification
REQ-031 Scenario: lw at 0x100, ack 3 cycles after req, rdata 0xDEADBEEF -> o_stall high for 4 cycles, then o_rdata=0xDEADBEEF in DONE.
REQ-032 Scenario: lb at 0x103, signed, rdata 0x80FFFFFF -> o_rdata=0xFFFFFF80; same with lbu -> o_rdata=0x00000080.
REQ-033 Scenario: sh at 0x202, wdata 0x0000ABCD -> o_bus_be=4'b1100, o_bus_addr=0x200, o_bus_wdata=0xABCDABCD, o_bus_we=1.
REQ-034 Scenario: lw at 0x101 -> o_misalign=1, o_bus_req stays 0, o_stall=0.
REQ-035 Scenario: lw with TIMEOUT_CYCLES=4 and no ack -> o_bus_err pulses once after 4 WAIT cycles, o_rdata=0, FSM returns to IDLE.
REQ-036 Scenario: reset driven low during WAIT -> o_bus_req=0 with no clock edge, and after release the next lw completes normally.
